// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring signed/unsigned integer divider for the EX stage.
// Latency: o_done WIDTH+3 cycles after the request cycle; 2 cycles for divide-by-zero and signed overflow.
// Backpressure: o_stall holds upstream pipeline registers from the request cycle through FIX; i_start ignored while busy.
// Ports: clk, resetn (async, active-low); i_start/i_signed/i_dividend/i_divisor request a divide;
//        i_flush aborts an operation in flight; o_stall/o_busy/o_done status; o_quotient/o_remainder results.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_raw;     // dividend as latched
  logic [WIDTH-1:0] dvs_raw;     // divisor as latched
  logic             sgn;         // signed operation
  logic [WIDTH-1:0] dvs_abs_r;   // working divisor magnitude
  logic [WIDTH-1:0] work;        // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   prem;        // partial remainder
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  // PREP-stage decode of the latched operands
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             div_zero, ovf;

  assign dvd_neg  = sgn & dvd_raw[WIDTH-1];
  assign dvs_neg  = sgn & dvs_raw[WIDTH-1];
  assign dvd_abs  = dvd_neg ? ('0 - dvd_raw) : dvd_raw;
  assign dvs_abs  = dvs_neg ? ('0 - dvs_raw) : dvs_raw;
  assign div_zero = (dvs_raw == '0);
  assign ovf      = sgn && (dvd_raw == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_raw == '1);

  // One restoring step: shift {prem, work} left, trial-subtract the divisor.
  // Carried one bit wider than prem so the borrow lands in the top bit.
  logic [WIDTH+1:0] shifted, trial;
  logic             q_bit;

  assign shifted = {prem, work[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_abs_r};
  assign q_bit   = ~trial[WIDTH+1];

  logic last_step;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && !i_flush) begin
          state_nxt = PREP;
          o_stall   = 1'b1;
        end
      end
      PREP: begin
        o_stall = 1'b1;
        o_busy  = 1'b1;
        if (i_flush)               state_nxt = IDLE;
        else if (div_zero || ovf)  state_nxt = DONE;
        else                       state_nxt = CALC;
      end
      CALC: begin
        o_stall = 1'b1;
        o_busy  = 1'b1;
        if (i_flush)        state_nxt = IDLE;
        else if (last_step) state_nxt = FIX;
      end
      FIX: begin
        o_stall   = 1'b1;
        o_busy    = 1'b1;
        state_nxt = i_flush ? IDLE : DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush freezes the datapath; the state register alone returns to IDLE,
  // so the visible results keep their previous values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_raw     <= '0;
      dvs_raw     <= '0;
      sgn         <= 1'b0;
      dvs_abs_r   <= '0;
      work        <= '0;
      prem        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (!i_flush) begin
      case (state)
        IDLE: begin
          if (i_start) begin
            dvd_raw <= i_dividend;
            dvs_raw <= i_divisor;
            sgn     <= i_signed;
          end
        end
        PREP: begin
          q_neg     <= dvd_neg ^ dvs_neg;
          r_neg     <= dvd_neg;
          work      <= dvd_abs;
          dvs_abs_r <= dvs_abs;
          prem      <= '0;
          cnt       <= '0;
          if (div_zero) begin
            o_quotient  <= '1;
            o_remainder <= dvd_raw;
          end else if (ovf) begin
            o_quotient  <= dvd_raw;
            o_remainder <= '0;
          end
        end
        CALC: begin
          prem <= q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
          work <= {work[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          o_quotient  <= q_neg ? ('0 - work) : work;
          o_remainder <= r_neg ? ('0 - prem[WIDTH-1:0]) : prem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_flush;
  logic        o_stall;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_flush     (i_flush),
    .o_stall     (o_stall),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    longint x, y;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 2;
    end else begin
      if (s) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'd0, a});
        y = longint'({32'd0, b});
      end
      q   = 32'(x / y);
      r   = 32'(x % y);
      lat = (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 2 : 35;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT idle; drives a one-cycle request.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit expect_done);
    logic [31:0] q, r;
    int          lat;
    model(a, b, s, q, r, lat);
    i_dividend = a;
    i_divisor  = b;
    i_signed   = s;
    i_start    = 1'b1;
    if (expect_done) begin
      exp_q.push_back('{q: q, r: r, done_cyc: cyc + lat});
      last_q = q;
      last_r = r;
    end
    @(negedge clk);
    check("stall_in_request_cycle", o_stall, 1);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy || o_done) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) check("timeout_waiting_for_done", 64'(exp_q.size()), 0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue(a, b, s, 1'b1);
    wait_idle();
  endtask

  // Monitor: every o_done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && o_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", o_quotient, e.q);
          check("remainder", o_remainder, e.r);
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("stall_low_in_done", o_stall, 0);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    resetn     = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    i_flush    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_stall", o_stall, 0);
    check("reset_quotient", o_quotient, 0);
    check("reset_remainder", o_remainder, 0);
    resetn = 1'b1;
    tick();

    // Directed cases
    run(32'd100, 32'd7, 1'b0);
    run(-32'sd7, 32'd2, 1'b1);
    run(32'd7, -32'sd2, 1'b1);
    run(32'd5, 32'd0, 1'b0);
    run(32'd5, 32'd0, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(-32'sd1, 32'd5, 1'b1);

    // Flush in CALC at cycle 10 after the request
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_busy", o_busy, 0);
    check("flush_stall", o_stall, 0);
    check("flush_quotient_kept", o_quotient, last_q);
    check("flush_remainder_kept", o_remainder, last_r);
    repeat (40) tick();
    run(32'd9, 32'd3, 1'b0);

    // Start pulses while busy (cycle 5) and in the DONE cycle (cycle 35) are ignored
    issue(32'd50, 32'd5, 1'b0, 1'b1);
    repeat (4) tick();
    i_dividend = 32'd77;
    i_divisor  = 32'd2;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (29) tick();
    i_dividend = 32'd81;
    i_divisor  = 32'd9;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_in_done_ignored", o_busy, 0);
    repeat (40) tick();
    check("no_second_done_pending", 64'(exp_q.size()), 0);

    // Asynchronous reset during CALC
    issue(32'd12345, 32'd6, 1'b0, 1'b0);
    repeat (8) tick();
    #3;
    resetn = 1'b0;
    #1;
    check("areset_busy", o_busy, 0);
    check("areset_stall", o_stall, 0);
    check("areset_done", o_done, 0);
    check("areset_quotient", o_quotient, 0);
    check("areset_remainder", o_remainder, 0);
    tick();
    #2;
    resetn = 1'b1;
    tick();
    run(32'hFFFF_FFFF, 32'h10, 1'b0);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run(a, b, s);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle radix-2 restoring integer divider for the EX stage. It accepts one signed or unsigned divide per request and produces the quotient and remainder. While the divide is in flight it drives a stall that holds the write enables of the upstream ID/EX and EX/MEM pipeline registers low. It returns a one-cycle done pulse so that the EX/MEM register captures the result on the following edge.

## Interface

- WIDTH, 32, operand and result width in bits (≥ 4)
- clk  in  1  clock, rising-edge
- resetn  in  1  reset, asynchronous, active-low
- i_start  in  1  request a divide; sampled only in IDLE
- i_signed  in  1  1 = two's-complement divide, 0 = unsigned
- i_dividend  in  WIDTH  dividend, sampled with i_start
- i_divisor  in  WIDTH  divisor, sampled with i_start
- i_flush  in  1  abort the current operation (pipeline flush)
- o_stall  out  1  hold upstream pipeline registers (drive their write enables low)
- o_busy  out  1  operation in progress (PREP, CALC or FIX)
- o_done  out  1  one-cycle pulse: result valid
- o_quotient  out  WIDTH  quotient; holds until the next completed operation
- o_remainder  out  WIDTH  remainder; holds until the next completed operation

## Operation

- **States:** IDLE, PREP, CALC, FIX, DONE.
- **IDLE:**
  - On i_start & !i_flush, latch operands and i_signed, then go to PREP.
  - Otherwise stay in IDLE.
- **PREP:**
  - Compute absolute values when signed; unsigned operands pass through unchanged.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Divisor == 0: result quotient = all ones, remainder = dividend (raw, as latched). Go to DONE.
  - Signed, dividend == 100…0, divisor == all ones: quotient = dividend, remainder = 0. Go to DONE.
  - Otherwise clear the iteration counter and the (WIDTH+1)-bit partial remainder, then go to CALC.
- **CALC:** one restoring step per cycle.
  - Shift {partial remainder, working dividend} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit 1; else restore it and set quotient bit 0.
  - After WIDTH steps, go to FIX.
- **FIX:**
  - Signed only: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register into o_quotient and o_remainder. Go to DONE.
- **DONE:** o_done = 1 for this cycle only, then IDLE. i_start in the DONE cycle is ignored.
- **i_flush:** in any state except IDLE, go to IDLE on the next edge. o_done is not asserted and o_quotient/o_remainder keep their previous values. In IDLE, flush wins over a simultaneous i_start.
- **Start while busy:** i_start in PREP, CALC or FIX is ignored. There is no queuing.
- **Arithmetic:** results are truncated toward zero. The remainder sign follows the dividend, so (q × divisor + r) == dividend modulo 2^WIDTH for all non-zero divisors.
- **Outputs:**
  - o_stall = (IDLE & i_start & !i_flush) | PREP | CALC | FIX. This is combinational, so the stall is asserted in the request cycle itself.
  - o_busy = PREP | CALC | FIX, registered state decode.

## Timing

- **Reset:** state = IDLE; o_busy = 0, o_done = 0, o_stall = 0 (given i_start = 0); o_quotient = 0, o_remainder = 0; counter and internal registers = 0.
- **Normal latency:** i_start is sampled at edge E. The states are then:
  - PREP in cycle E+1
  - CALC in cycles E+2 … E+WIDTH+1
  - FIX in cycle E+WIDTH+2
  - DONE in cycle E+WIDTH+3
- o_done is high for exactly one cycle, WIDTH+3 cycles after the request cycle (35 for WIDTH = 32). Results are valid in the same cycle as o_done.
- **Special-case latency:** divide by zero and signed overflow reach DONE in cycle E+2, so o_done is high 2 cycles after the request cycle.
- o_stall is high from the request cycle through FIX inclusive and low in DONE. The consumer therefore captures the result on the edge ending DONE.
- **Back-to-back:** the earliest next accepted i_start is in the cycle after DONE.
- **Reset mid-operation:** asynchronous return to the reset values regardless of state; no o_done is produced.

## Test plan

- **Unsigned, basic:** i_signed = 0, 100 / 7 → o_done in cycle 35 after the request; q = 14, r = 2; o_stall high for cycles 0–34 and low in cycle 35.
- **Signed mixed signs:** −7 / 2 → q = 0xFFFFFFFD (−3), r = 0xFFFFFFFF (−1). Also 7 / −2 → q = −3, r = 1.
- **Divide by zero:** 5 / 0 (either signedness) → o_done in cycle 2; q = 0xFFFFFFFF, r = 5. Signed overflow: 0x80000000 / 0xFFFFFFFF signed → o_done in cycle 2; q = 0x80000000, r = 0.
- **Flush mid-CALC:** assert i_flush for 1 cycle at cycle 10 → IDLE next edge; o_busy and o_stall fall; no o_done; o_quotient/o_remainder unchanged. A fresh 9 / 3 afterwards → q = 3, r = 0.
- **Start while busy:** pulse i_start with new operands at cycles 5 and 35 (the DONE cycle) → both ignored; the original result is returned; no second o_done.
- **Reset mid-operation:** deassert resetn asynchronously during CALC → all outputs 0 immediately; after release, 0xFFFFFFFF / 0x10 unsigned → q = 0x0FFFFFFF, r = 0xF.
